// File: rtl/encode_framer.sv
// encode_framer: frames a byte stream into 9-bit K/data characters for an 8b/10b encoder, with commas for idle, fill and alignment.
module encode_framer #(
  parameter int ALIGN_PERIOD = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_sof,
  input  logic        s_eof,
  output logic        s_ready,
  output logic [8:0]  dataout,
  output logic        in_pkt,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count
);
  localparam logic [8:0] K_COMMA = 9'h1BC;
  localparam logic [8:0] K_SOF   = 9'h1FB;
  localparam logic [8:0] K_EOF   = 9'h1FD;
  localparam logic [8:0] K_ABORT = 9'h1FE;
  localparam logic [15:0] AMAX   = 16'(ALIGN_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, DATA, EOF} state_t;
  state_t      state, nstate;
  logic [15:0] acnt;
  logic        first, nfirst, align_due, err_inc, pkt_inc;
  logic [8:0]  sym;
  assign align_due = (acnt == AMAX);
  always_comb begin
    nstate  = state;
    nfirst  = first;
    sym     = K_COMMA;
    s_ready = 1'b0;
    err_inc = 1'b0;
    pkt_inc = 1'b0;
    case (state)
      IDLE: begin
        s_ready = !s_sof;
        if (!align_due && s_valid && s_sof) begin
          sym    = K_SOF;
          nstate = DATA;
          nfirst = 1'b1;
        end else begin
          err_inc = s_valid && !s_sof;
        end
      end
      DATA: begin
        s_ready = !align_due && !(s_sof && !first);
        if (!align_due && s_valid) begin
          if (s_sof && !first) begin
            sym     = K_ABORT;
            nstate  = IDLE;
            err_inc = 1'b1;
          end else begin
            sym    = {1'b0, s_data};
            nfirst = 1'b0;
            nstate = s_eof ? EOF : DATA;
          end
        end
      end
      default: begin
        // EOF goes out even when a comma is due; the run limit allows for it
        sym     = K_EOF;
        pkt_inc = 1'b1;
        nstate  = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      dataout   <= K_COMMA;
      in_pkt    <= 1'b0;
      first     <= 1'b0;
      acnt      <= '0;
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      state     <= nstate;
      dataout   <= sym;
      in_pkt    <= (nstate != IDLE);
      first     <= nfirst;
      acnt      <= (sym == K_COMMA) ? '0 : align_due ? acnt : acnt + 16'd1;
      pkt_count <= pkt_count + {15'd0, pkt_inc};
      err_count <= err_count + {15'd0, err_inc};
    end
  end
endmodule
